ex_stage: RTL and testbench

- Execute pipeline stage of the in-order MIPS core, between the decode stage and the memory stage.
- Registers the decode bundle and drives one instance of the core ALU.
- Owns the HI/LO registers, a single-cycle multiplier and a 32-iteration restoring divider.
- Raises the integer-overflow exception and publishes a bypass bus back to decode.

---
 rtl/ex_stage.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the in-order MIPS core; owns HI/LO, a one-cycle multiplier and a restoring divider.
// Latency: one cycle for ALU/mult/mf/mt ops; div/divu leave 33 cycles after entry (32 RUN cycles + DONE).
// Backpressure: valid/allowin handshake; a div holds EX (and DONE) until MEM accepts, an exiting op frees EX same cycle.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   flush, ms_ex        WB flush (drops EX, aborts divider) / older MEM-WB exception (blocks HI/LO commit)
//   ds_to_es_*          decode handshake; bus = {ov_en, md_op[7:0], dest[4:0], alu_op[10:0], src2, src1, pc}
//   es_to_ms_*          memory handshake; bus = {ex_ov, dest[4:0], result[31:0], pc[31:0]}
//   es_fwd_*            bypass to decode: valid writer, dest, data, busy (result not ready yet)
//
// alu_op is one-hot: 0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 nor, 6 or, 7 xor, 8 sll, 9 srl, 10 sra.
// Overflow is only meaningful for add/sub; shifts take the amount from A[4:0] and the value from B.

module ex_stage_alu (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [10:0] i_op,
  output logic [31:0] o_result,
  output logic        o_overflow
);

  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [31:0] w_slt;
  logic [31:0] w_sltu;
  logic [31:0] w_sll;
  logic [31:0] w_srl;
  logic [31:0] w_sra;
  logic        w_add_ov;
  logic        w_sub_ov;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;
  assign w_slt  = {31'd0, ($signed(i_a) < $signed(i_b))};
  assign w_sltu = {31'd0, (i_a < i_b)};
  assign w_sll  = i_b << i_a[4:0];
  assign w_srl  = i_b >> i_a[4:0];
  assign w_sra  = $signed(i_b) >>> i_a[4:0];

  // Signed overflow: operands agree in sign (add) or differ (sub) and the result sign flips.
  assign w_add_ov = (i_a[31] == i_b[31]) && (w_sum[31]  != i_a[31]);
  assign w_sub_ov = (i_a[31] != i_b[31]) && (w_diff[31] != i_a[31]);

  // One-hot AND-OR mux; an all-zero op yields 0.
  assign o_result = ({32{i_op[0]}}  & w_sum)
                  | ({32{i_op[1]}}  & w_diff)
                  | ({32{i_op[2]}}  & w_slt)
                  | ({32{i_op[3]}}  & w_sltu)
                  | ({32{i_op[4]}}  & (i_a & i_b))
                  | ({32{i_op[5]}}  & ~(i_a | i_b))
                  | ({32{i_op[6]}}  & (i_a | i_b))
                  | ({32{i_op[7]}}  & (i_a ^ i_b))
                  | ({32{i_op[8]}}  & w_sll)
                  | ({32{i_op[9]}}  & w_srl)
                  | ({32{i_op[10]}} & w_sra);

  assign o_overflow = (i_op[0] & w_add_ov) | (i_op[1] & w_sub_ov);

endmodule

module ex_stage #(
  parameter int DS_BUS_W = 121,
  parameter int ES_BUS_W = 70
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                ms_ex,
  input  logic                ds_to_es_valid,
  output logic                es_allowin,
  input  logic [DS_BUS_W-1:0] ds_to_es_bus,
  output logic                es_to_ms_valid,
  input  logic                ms_allowin,
  output logic [ES_BUS_W-1:0] es_to_ms_bus,
  output logic                es_fwd_valid,
  output logic [4:0]          es_fwd_dest,
  output logic [31:0]         es_fwd_data,
  output logic                es_fwd_busy
);

  localparam int MD_MULT  = 0;
  localparam int MD_MULTU = 1;
  localparam int MD_DIV   = 2;
  localparam int MD_DIVU  = 3;
  localparam int MD_MFHI  = 4;
  localparam int MD_MFLO  = 5;
  localparam int MD_MTHI  = 6;
  localparam int MD_MTLO  = 7;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Pipeline registers
  logic                r_es_valid;
  logic [DS_BUS_W-1:0] r_ds_bus;

  // HI/LO architectural registers
  logic [31:0]         r_hi;
  logic [31:0]         r_lo;

  // Divider state
  div_state_t          r_div_st;
  logic [4:0]          r_div_cnt;
  logic [31:0]         r_div_rem;   // partial remainder; signed-fixed remainder in DONE
  logic [31:0]         r_div_quo;   // dividend shifts out as quotient bits shift in
  logic [31:0]         r_div_dvs;   // |divisor|
  logic                r_div_neg_q;
  logic                r_div_neg_r;
  logic                r_div_kill;  // an older exception was seen while dividing

  // Decoded fields of the occupying instruction
  logic [31:0] w_pc;
  logic [31:0] w_src1;
  logic [31:0] w_src2;
  logic [10:0] w_alu_op;
  logic [4:0]  w_dest;
  logic [7:0]  w_md_op;
  logic        w_ov_en;

  assign w_pc     = r_ds_bus[31:0];
  assign w_src1   = r_ds_bus[63:32];
  assign w_src2   = r_ds_bus[95:64];
  assign w_alu_op = r_ds_bus[106:96];
  assign w_dest   = r_ds_bus[111:107];
  assign w_md_op  = r_ds_bus[119:112];
  assign w_ov_en  = r_ds_bus[120];

  logic [31:0] w_alu_res;
  logic        w_alu_ov;

  ex_stage_alu u_alu (
    .i_a        (w_src1),
    .i_b        (w_src2),
    .i_op       (w_alu_op),
    .o_result   (w_alu_res),
    .o_overflow (w_alu_ov)
  );

  // Handshake
  logic w_is_div;
  logic w_ready_go;
  logic w_exit;
  logic w_ex_ov;
  logic w_commit;

  assign w_is_div   = w_md_op[MD_DIV] | w_md_op[MD_DIVU];
  assign w_ready_go = !(r_es_valid && w_is_div && (r_div_st != DIV_DONE));
  assign es_allowin     = !r_es_valid || (w_ready_go && ms_allowin);
  assign es_to_ms_valid = r_es_valid && w_ready_go;
  assign w_exit     = r_es_valid && w_ready_go && ms_allowin;
  assign w_ex_ov    = w_ov_en & w_alu_ov;

  // HI/LO are written only by an instruction that actually retires from EX cleanly.
  assign w_commit = w_exit && !flush && !ms_ex && !w_ex_ov && !(w_is_div && r_div_kill);

  // Result / output bus
  logic [31:0] w_result;
  logic [4:0]  w_dest_out;

  assign w_result   = w_md_op[MD_MFHI] ? r_hi :
                      w_md_op[MD_MFLO] ? r_lo : w_alu_res;
  assign w_dest_out = w_ex_ov ? 5'd0 : w_dest;

  assign es_to_ms_bus = {w_ex_ov, w_dest_out, w_result, w_pc};
  assign es_fwd_valid = r_es_valid && (w_dest != 5'd0) && !w_ex_ov;
  assign es_fwd_dest  = w_dest_out;
  assign es_fwd_data  = w_result;
  assign es_fwd_busy  = r_es_valid && !w_ready_go;

  // Multiplier: 64x64 product of extended operands, low 64 bits are exact.
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;

  assign w_prod_s = {{32{w_src1[31]}}, w_src1} * {{32{w_src2[31]}}, w_src2};
  assign w_prod_u = {32'd0, w_src1} * {32'd0, w_src2};

  // Divider operand magnitudes (signed only for div)
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_abs;
  logic [31:0] w_b_abs;

  assign w_a_neg = w_md_op[MD_DIV] & w_src1[31];
  assign w_b_neg = w_md_op[MD_DIV] & w_src2[31];
  assign w_a_abs = w_a_neg ? (~w_src1 + 32'd1) : w_src1;
  assign w_b_abs = w_b_neg ? (~w_src2 + 32'd1) : w_src2;

  // One restoring step: bring down the next dividend bit and try to subtract.
  // When the subtraction succeeds the difference is below the divisor, so 32 bits hold it.
  logic [32:0] w_trial;
  logic [31:0] w_trial_sub;
  logic        w_ge;
  logic [31:0] w_rem_next;
  logic [31:0] w_quo_next;

  assign w_trial     = {r_div_rem, r_div_quo[31]};
  assign w_trial_sub = w_trial[31:0] - r_div_dvs;
  assign w_ge        = (w_trial >= {1'b0, r_div_dvs});
  assign w_rem_next  = w_ge ? w_trial_sub : w_trial[31:0];
  assign w_quo_next  = {r_div_quo[30:0], w_ge};

  // Pipeline valid / bus capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_es_valid <= 1'b0;
      r_ds_bus   <= '0;
    end else if (flush) begin
      r_es_valid <= 1'b0;
    end else if (es_allowin) begin
      r_es_valid <= ds_to_es_valid;
      if (ds_to_es_valid) begin
        r_ds_bus <= ds_to_es_bus;
      end
    end
  end

  // Divider FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_st    <= DIV_IDLE;
      r_div_cnt   <= 5'd0;
      r_div_rem   <= 32'd0;
      r_div_quo   <= 32'd0;
      r_div_dvs   <= 32'd0;
      r_div_neg_q <= 1'b0;
      r_div_neg_r <= 1'b0;
      r_div_kill  <= 1'b0;
    end else if (flush) begin
      r_div_st   <= DIV_IDLE;
      r_div_kill <= 1'b0;
    end else begin
      case (r_div_st)
        DIV_IDLE: begin
          if (r_es_valid && w_is_div && !ms_ex) begin
            r_div_st    <= DIV_RUN;
            r_div_cnt   <= 5'd0;
            r_div_rem   <= 32'd0;
            r_div_quo   <= w_a_abs;
            r_div_dvs   <= w_b_abs;
            r_div_neg_q <= w_a_neg ^ w_b_neg;
            r_div_neg_r <= w_a_neg;
            r_div_kill  <= 1'b0;
          end
        end
        DIV_RUN: begin
          r_div_cnt <= r_div_cnt + 5'd1;
          if (ms_ex) begin
            r_div_kill <= 1'b1;
          end
          if (r_div_cnt == 5'd31) begin
            // Last bit: fold the sign fix into the final write so DONE holds the answer.
            r_div_st  <= DIV_DONE;
            r_div_quo <= r_div_neg_q ? (~w_quo_next + 32'd1) : w_quo_next;
            r_div_rem <= r_div_neg_r ? (~w_rem_next + 32'd1) : w_rem_next;
          end else begin
            r_div_quo <= w_quo_next;
            r_div_rem <= w_rem_next;
          end
        end
        DIV_DONE: begin
          if (ms_ex) begin
            r_div_kill <= 1'b1;
          end
          if (w_exit) begin
            r_div_st <= DIV_IDLE;
          end
        end
        default: begin
          r_div_st <= DIV_IDLE;
        end
      endcase
    end
  end

  // HI/LO commit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_commit) begin
      if (w_md_op[MD_MULT]) begin
        r_hi <= w_prod_s[63:32];
        r_lo <= w_prod_s[31:0];
      end else if (w_md_op[MD_MULTU]) begin
        r_hi <= w_prod_u[63:32];
        r_lo <= w_prod_u[31:0];
      end else if (w_is_div) begin
        r_hi <= r_div_rem;
        r_lo <= r_div_quo;
      end else if (w_md_op[MD_MTHI]) begin
        r_hi <= w_src1;
      end else if (w_md_op[MD_MTLO]) begin
        r_lo <= w_src1;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  typedef struct packed {
    logic        ov_en;
    logic [7:0]  md;
    logic [4:0]  dest;
    logic [10:0] aop;
    logic [31:0] s2;
    logic [31:0] s1;
    logic [31:0] pc;
  } ins_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         ms_ex;
  logic         ds_to_es_valid;
  logic         es_allowin;
  logic [120:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic         ms_allowin = 1'b1;
  logic [69:0]  es_to_ms_bus;
  logic         es_fwd_valid;
  logic [4:0]   es_fwd_dest;
  logic [31:0]  es_fwd_data;
  logic         es_fwd_busy;

  ex_stage #(.DS_BUS_W(121), .ES_BUS_W(70)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .ms_ex          (ms_ex),
    .ds_to_es_valid (ds_to_es_valid),
    .es_allowin     (es_allowin),
    .ds_to_es_bus   (ds_to_es_bus),
    .es_to_ms_valid (es_to_ms_valid),
    .ms_allowin     (ms_allowin),
    .es_to_ms_bus   (es_to_ms_bus),
    .es_fwd_valid   (es_fwd_valid),
    .es_fwd_dest    (es_fwd_dest),
    .es_fwd_data    (es_fwd_data),
    .es_fwd_busy    (es_fwd_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  ins_t        mq[$];
  int          head_age = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [69:0] last_bus = '0;
  int          last_age = 0;
  int          n_exit = 0;
  int          ms_mode = 0;   // 0: always accept, 1: random, 2: refuse

  function automatic void model_alu(input ins_t i, output logic [31:0] res, output logic ov);
    longint sa, sb, s;
    int     sh, v;
    sa = longint'(int'(i.s1));
    sb = longint'(int'(i.s2));
    sh = int'(i.s1[4:0]);
    res = 32'd0;
    ov  = 1'b0;
    if (i.aop[0]) begin
      s = sa + sb; res = s[31:0]; ov = (s != longint'(int'(s[31:0])));
    end else if (i.aop[1]) begin
      s = sa - sb; res = s[31:0]; ov = (s != longint'(int'(s[31:0])));
    end else if (i.aop[2]) res = (int'(i.s1) < int'(i.s2)) ? 32'd1 : 32'd0;
    else if (i.aop[3]) res = (i.s1 < i.s2) ? 32'd1 : 32'd0;
    else if (i.aop[4]) res = i.s1 & i.s2;
    else if (i.aop[5]) res = ~(i.s1 | i.s2);
    else if (i.aop[6]) res = i.s1 | i.s2;
    else if (i.aop[7]) res = i.s1 ^ i.s2;
    else if (i.aop[8]) res = i.s2 << sh;
    else if (i.aop[9]) res = i.s2 >> sh;
    else if (i.aop[10]) begin v = int'(i.s2); v = v >>> sh; res = v; end
  endfunction

  function automatic logic [69:0] model_bus(input ins_t i);
    logic [31:0] r;
    logic        ov, xo;
    model_alu(i, r, ov);
    if (i.md[4]) r = m_hi;
    else if (i.md[5]) r = m_lo;
    xo = i.ov_en & ov;
    return {xo, (xo ? 5'd0 : i.dest), r, i.pc};
  endfunction

  task automatic model_commit(input ins_t i);
    longint      a, b, q, r;
    logic [63:0] p;
    if (i.md[0]) begin
      p = 64'(longint'(int'(i.s1)) * longint'(int'(i.s2)));
      m_hi = p[63:32]; m_lo = p[31:0];
    end else if (i.md[1]) begin
      p = {32'd0, i.s1} * {32'd0, i.s2};
      m_hi = p[63:32]; m_lo = p[31:0];
    end else if (i.md[2] || i.md[3]) begin
      a = i.md[2] ? longint'(int'(i.s1)) : longint'(i.s1);
      b = i.md[2] ? longint'(int'(i.s2)) : longint'(i.s2);
      if (b == 0) begin
        // all-ones raw quotient, negated if the dividend is negative; remainder = dividend
        q = (a < 0) ? 64'd1 : 64'hFFFF_FFFF;
        r = a;
      end else begin
        q = a / b;
        r = a % b;
      end
      m_lo = q[31:0]; m_hi = r[31:0];
    end else if (i.md[6]) m_hi = i.s1;
    else if (i.md[7]) m_lo = i.s1;
  endtask

  task automatic monitor_cycle();
    logic        occ, rdy, ex_exit;
    logic [69:0] eb;
    ins_t        h;
    h   = '0;
    eb  = '0;
    occ = (mq.size() != 0);
    if (occ) h = mq[0];
    rdy = !occ || !(h.md[2] || h.md[3]) || (head_age >= 33);
    ex_exit = occ && rdy && ms_allowin;
    check_eq("to_ms_valid", 70'(es_to_ms_valid), 70'(occ && rdy));
    check_eq("allowin", 70'(es_allowin), 70'(!occ || (rdy && ms_allowin)));
    check_eq("fwd_busy", 70'(es_fwd_busy), 70'(occ && !rdy));
    if (occ) begin
      eb = model_bus(h);
      check_eq("fwd_valid", 70'(es_fwd_valid), 70'(eb[68:64] != 5'd0));
      if (!eb[69]) check_eq("fwd_dest", 70'(es_fwd_dest), 70'(eb[68:64]));
      check_eq("fwd_data", 70'(es_fwd_data), 70'(eb[63:32]));
    end else begin
      check_eq("fwd_valid_idle", 70'(es_fwd_valid), 70'(0));
    end
    if (flush) begin
      mq.delete();
      head_age = 0;
    end else begin
      if (ex_exit) begin
        check_eq("to_ms_bus", es_to_ms_bus, eb);
        last_bus = es_to_ms_bus;
        last_age = head_age;
        n_exit++;
        if (!ms_ex && !eb[69]) model_commit(h);
        void'(mq.pop_front());
      end
      if (ds_to_es_valid && es_allowin) begin
        mq.push_back(ins_t'(ds_to_es_bus));
        head_age = 0;
      end else if (mq.size() != 0) begin
        head_age++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) monitor_cycle();
  end

  // MEM-side acceptance, changed after main stimulus settles
  always @(posedge clk) begin
    #2;
    if (ms_mode == 1) ms_allowin = ($urandom_range(0, 2) != 0);
    else ms_allowin = (ms_mode == 0);
  end

  // ---------------- stimulus helpers ----------------
  function automatic ins_t mk(input int md_bit, input int aop_bit, input logic [31:0] s1,
                              input logic [31:0] s2, input logic [4:0] dest, input logic ov_en);
    ins_t i;
    i = '0;
    if (md_bit >= 0) i.md = 8'(1) << md_bit;
    i.aop   = 11'(1) << aop_bit;
    i.s1    = s1;
    i.s2    = s2;
    i.dest  = dest;
    i.ov_en = ov_en;
    i.pc    = $urandom;
    return i;
  endfunction

  task automatic send(input ins_t i);
    int n;
    n = 0;
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = i;
    @(negedge clk);
    while (!es_allowin && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check_eq("send_timeout", 70'(1), 70'(0));
    @(posedge clk);
    #1;
    ds_to_es_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (mq.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) check_eq("drain_timeout", 70'(1), 70'(0));
  endtask

  task automatic wait_age(input int age);
    int n;
    n = 0;
    while (!(mq.size() != 0 && head_age >= age) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) check_eq("age_timeout", 70'(1), 70'(0));
  endtask

  task automatic read_hl(input logic hi, output logic [31:0] v);
    send(mk(hi ? 4 : 5, 0, 32'd0, 32'd0, 5'd3, 1'b0));
    drain();
    v = last_bus[63:32];
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    int   k;
    k = $urandom_range(0, 99);
    i = mk(-1, $urandom_range(0, 10), pick(), pick(), 5'($urandom_range(0, 31)), 1'b0);
    if (k < 60) begin
      if (i.aop[0] || i.aop[1]) i.ov_en = 1'($urandom_range(0, 1));
    end else begin
      i.aop = 11'd1;
      if (k < 66) i.md = 8'h01;
      else if (k < 72) i.md = 8'h02;
      else if (k < 75) i.md = 8'h04;
      else if (k < 78) i.md = 8'h08;
      else if (k < 84) i.md = 8'h10;
      else if (k < 90) i.md = 8'h20;
      else if (k < 95) i.md = 8'h40;
      else i.md = 8'h80;
      if (!(i.md[4] || i.md[5])) i.dest = 5'd0;
    end
    return i;
  endfunction

  // ---------------- main sequence ----------------
  logic [31:0] v;
  int          exit0;

  initial begin
    rst = 1'b1; flush = 1'b0; ms_ex = 1'b0;
    ds_to_es_valid = 1'b0; ds_to_es_bus = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_to_ms_valid", 70'(es_to_ms_valid), 70'(0));
    check_eq("rst_allowin", 70'(es_allowin), 70'(1));
    check_eq("rst_bus", es_to_ms_bus, 70'(0));
    check_eq("rst_fwd_valid", 70'(es_fwd_valid), 70'(0));
    check_eq("rst_fwd_busy", 70'(es_fwd_busy), 70'(0));
    check_eq("rst_fwd_data", 70'(es_fwd_data), 70'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // overflowing add
    send(mk(-1, 0, 32'h7FFF_FFFF, 32'd1, 5'd5, 1'b1)); drain();
    check_eq("add_ov_flag", 70'(last_bus[69]), 70'(1));
    check_eq("add_ov_dest", 70'(last_bus[68:64]), 70'(0));
    send(mk(-1, 0, 32'h7FFF_FFFF, 32'd1, 5'd5, 1'b0)); drain();
    check_eq("add_res", 70'(last_bus[63:32]), 70'(32'h8000_0000));
    check_eq("add_dest", 70'(last_bus[68:64]), 70'(5));
    check_eq("add_noov", 70'(last_bus[69]), 70'(0));

    // mult / multu then back-to-back reads
    send(mk(0, 0, 32'hFFFF_FFFE, 32'd3, 5'd0, 1'b0));
    read_hl(1'b1, v); check_eq("mult_hi", 70'(v), 70'(32'hFFFF_FFFF));
    read_hl(1'b0, v); check_eq("mult_lo", 70'(v), 70'(32'hFFFF_FFFA));
    send(mk(1, 0, 32'hFFFF_FFFE, 32'd3, 5'd0, 1'b0));
    read_hl(1'b1, v); check_eq("multu_hi", 70'(v), 70'(32'h0000_0002));
    read_hl(1'b0, v); check_eq("multu_lo", 70'(v), 70'(32'hFFFF_FFFA));

    // div -7/2, no backpressure
    send(mk(2, 0, 32'hFFFF_FFF9, 32'd2, 5'd0, 1'b0)); drain();
    check_eq("div_exit_age", 70'(last_age), 70'(33));
    read_hl(1'b0, v); check_eq("div_lo", 70'(v), 70'(32'hFFFF_FFFD));
    read_hl(1'b1, v); check_eq("div_hi", 70'(v), 70'(32'hFFFF_FFFF));

    // div 9/-4 held in DONE for 5 extra cycles
    send(mk(2, 0, 32'd9, 32'hFFFF_FFFC, 5'd0, 1'b0));
    ms_mode = 2;
    wait_age(38);
    ms_mode = 0;
    drain();
    check_eq("div_hold_age", 70'(last_age), 70'(38));
    read_hl(1'b0, v); check_eq("div_hold_lo", 70'(v), 70'(32'hFFFF_FFFE));
    read_hl(1'b1, v); check_eq("div_hold_hi", 70'(v), 70'(32'd1));

    // divu by zero
    send(mk(3, 0, 32'd7, 32'd0, 5'd0, 1'b0)); drain();
    check_eq("divu0_noex", 70'(last_bus[69]), 70'(0));
    read_hl(1'b0, v); check_eq("divu0_lo", 70'(v), 70'(32'hFFFF_FFFF));
    read_hl(1'b1, v); check_eq("divu0_hi", 70'(v), 70'(32'd7));

    // mthi exiting alongside an older exception must not commit
    send(mk(6, 0, 32'h0000_1234, 32'd0, 5'd0, 1'b0));
    ms_ex = 1'b1;
    @(posedge clk); #1;
    ms_ex = 1'b0;
    read_hl(1'b1, v); check_eq("msex_hi_kept", 70'(v), 70'(32'd7));

    // flush during RUN
    send(mk(2, 0, 32'd100, 32'd3, 5'd0, 1'b0));
    wait_age(11);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    read_hl(1'b1, v); check_eq("flush_hi_kept", 70'(v), 70'(32'd7));
    read_hl(1'b0, v); check_eq("flush_lo_kept", 70'(v), 70'(32'hFFFF_FFFF));
    send(mk(2, 0, 32'd100, 32'd7, 5'd0, 1'b0)); drain();
    check_eq("post_flush_age", 70'(last_age), 70'(33));
    read_hl(1'b0, v); check_eq("post_flush_lo", 70'(v), 70'(32'd14));
    read_hl(1'b1, v); check_eq("post_flush_hi", 70'(v), 70'(32'd2));

    // sll, then a random stream under random MEM backpressure
    send(mk(-1, 8, 32'd4, 32'd1, 5'd9, 1'b0)); drain();
    check_eq("sll_res", 70'(last_bus[63:32]), 70'(32'h10));
    ms_mode = 1;
    exit0 = n_exit;
    for (int k = 0; k < 300; k++) begin
      send(rand_ins());
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();
    check_eq("stream_count", 70'(n_exit - exit0), 70'(300));
    ms_mode = 0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
